// File: rtl/id_hazard_tracker_pkg.sv
// rtl/id_hazard_tracker_pkg.sv - shared types and constants for the ID-stage hazard tracker
package id_hazard_tracker_pkg;

    localparam int ADDR_W = 5;

    // Register $0 is hardwired to zero, so it never carries a real dependency
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              reg_write;
        logic [ADDR_W-1:0] write_addr;
        logic              mem_read;
    } hazard_tag_t;

    localparam hazard_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/id_hazard_tracker_match.sv
// rtl/id_hazard_tracker_match.sv - load-use compare of one source register against one stage tag
module hazard_match
    import id_hazard_tracker_pkg::*;
(
    input  logic              i_use,
    input  logic [ADDR_W-1:0] i_src,
    input  hazard_tag_t       i_tag,
    output logic              o_match
);

    // Only a pending load writing the same non-zero register is a hazard
    assign o_match = i_use
                   && (i_src != ZERO_REG)
                   && i_tag.reg_write
                   && i_tag.mem_read
                   && (i_tag.write_addr == i_src);

endmodule

// File: rtl/id_hazard_tracker.sv
// rtl/id_hazard_tracker.sv - EX/MEM write-tag pipeline and load-use stall generation (optional HAZARD_STATS_EN counters)
module id_hazard_tracker #(
    parameter int ADDR_W = id_hazard_tracker_pkg::ADDR_W
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [ADDR_W-1:0] id_write_addr,
    input  logic              flush,
    output logic              ID_EX_RegWrite,
    output logic [ADDR_W-1:0] ID_EX_WriteAddr,
    output logic              ID_EX_MemRead,
    output logic              EX_MEM_RegWrite,
    output logic [ADDR_W-1:0] EX_MEM_WriteAddr,
    output logic              EX_MEM_MemRead,
    output logic              stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  load_use_events
`endif
);

    import id_hazard_tracker_pkg::*;

    hazard_tag_t r_ex_tag;
    hazard_tag_t r_mem_tag;
    hazard_tag_t w_id_tag;
    hazard_tag_t w_ex_next;
    logic        w_rs_ex;
    logic        w_rt_ex;
    logic        w_rs_mem;
    logic        w_rt_mem;
    logic        w_stall;

    hazard_match u_rs_ex  (.i_use(id_use_rs), .i_src(id_rs), .i_tag(r_ex_tag),  .o_match(w_rs_ex));
    hazard_match u_rt_ex  (.i_use(id_use_rt), .i_src(id_rt), .i_tag(r_ex_tag),  .o_match(w_rt_ex));
    hazard_match u_rs_mem (.i_use(id_use_rs), .i_src(id_rs), .i_tag(r_mem_tag), .o_match(w_rs_mem));
    hazard_match u_rt_mem (.i_use(id_use_rt), .i_src(id_rt), .i_tag(r_mem_tag), .o_match(w_rt_mem));

    // Stall only for a live, unflushed instruction; a flush overrides any hazard
    always_comb begin
        w_stall = id_valid && !flush && (w_rs_ex || w_rt_ex || w_rs_mem || w_rt_mem);
    end

    // Build the tag the ID instruction carries into EX; writes to $0 are dropped
    always_comb begin
        w_id_tag            = BUBBLE_TAG;
        w_id_tag.reg_write  = id_reg_write && (id_write_addr != ZERO_REG);
        w_id_tag.write_addr = id_write_addr;
        w_id_tag.mem_read   = id_mem_read;
        w_ex_next           = (w_stall || flush || !id_valid) ? BUBBLE_TAG : w_id_tag;
    end

    // Advance the EX and MEM tags unless the whole pipeline is frozen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_tag  <= BUBBLE_TAG;
            r_mem_tag <= BUBBLE_TAG;
        end else if (!hold) begin
            r_mem_tag <= r_ex_tag;
            r_ex_tag  <= w_ex_next;
        end
    end

    assign stall            = w_stall;
    assign ID_EX_RegWrite   = r_ex_tag.reg_write;
    assign ID_EX_WriteAddr  = r_ex_tag.write_addr;
    assign ID_EX_MemRead    = r_ex_tag.mem_read;
    assign EX_MEM_RegWrite  = r_mem_tag.reg_write;
    assign EX_MEM_WriteAddr = r_mem_tag.write_addr;
    assign EX_MEM_MemRead   = r_mem_tag.mem_read;

`ifdef HAZARD_STATS_EN
    logic             r_stall_q;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_load_use_events;

    // Count stalled cycles and the first cycle of each stall episode; counters wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_q         <= 1'b0;
            r_stall_cycles    <= '0;
            r_load_use_events <= '0;
        end else if (!hold) begin
            r_stall_q <= w_stall;
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_stall && !r_stall_q) begin
                r_load_use_events <= r_load_use_events + 1'b1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign load_use_events = r_load_use_events;
`endif

endmodule

// File: tb/tb_id_hazard_tracker.sv
// tb/tb_id_hazard_tracker.sv - scoreboard bench for id_hazard_tracker
module tb_id_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_write_addr;
    logic       flush;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_WriteAddr;
    logic       ID_EX_MemRead;
    logic       EX_MEM_RegWrite;
    logic [4:0] EX_MEM_WriteAddr;
    logic       EX_MEM_MemRead;
    logic       stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] load_use_events;
`endif

    id_hazard_tracker dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_write_addr(id_write_addr), .flush(flush),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_WriteAddr(ID_EX_WriteAddr),
        .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_WriteAddr(EX_MEM_WriteAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .stall(stall)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .load_use_events(load_use_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       rw;
        logic       mr;
        logic [4:0] wa;
        logic       fl;
        logic       hd;
    } stim_t;

    // Observation vector: {stall, EX tag {w,addr,m}, MEM tag {w,addr,m}}
    logic [14:0] q[$];
    logic [6:0]  m_ex;
    logic [6:0]  m_mem;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic stim_t op(input logic v, input logic urs, input logic [4:0] rs,
                                 input logic urt, input logic [4:0] rt, input logic rw,
                                 input logic mr, input logic [4:0] wa, input logic fl,
                                 input logic hd);
        op = '{v, urs, rs, urt, rt, rw, mr, wa, fl, hd};
    endfunction

    function automatic stim_t ld(input logic [4:0] wa);
        ld = op(1, 1, 5'd29, 0, 0, 1, 1, wa, 0, 0);
    endfunction

    function automatic stim_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                                  input logic fl, input logic hd);
        alu = op(1, 1, rs, 1, rt, 1, 0, wa, fl, hd);
    endfunction

    function automatic stim_t nop();
        nop = op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic hit(input logic u, input logic [4:0] s, input logic [6:0] t);
        hit = u && (s != 5'd0) && t[6] && t[0] && (t[5:1] == s);
    endfunction

    function automatic logic [14:0] observe();
        observe = {stall, ID_EX_RegWrite, ID_EX_WriteAddr, ID_EX_MemRead,
                   EX_MEM_RegWrite, EX_MEM_WriteAddr, EX_MEM_MemRead};
    endfunction

    task automatic apply(input stim_t s);
        logic st;
        id_valid = s.v; id_use_rs = s.urs; id_rs = s.rs; id_use_rt = s.urt; id_rt = s.rt;
        id_reg_write = s.rw; id_mem_read = s.mr; id_write_addr = s.wa;
        flush = s.fl; hold = s.hd;
        st = s.v && !s.fl && (hit(s.urs, s.rs, m_ex) || hit(s.urt, s.rt, m_ex) ||
                              hit(s.urs, s.rs, m_mem) || hit(s.urt, s.rt, m_mem));
        q.push_back({st, m_ex, m_mem});
        if (!s.hd) begin
            m_mem = m_ex;
            m_ex  = (st || s.fl || !s.v) ? 7'd0 : {s.rw && (s.wa != 5'd0), s.wa, s.mr};
        end
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        apply(nop());
        q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ex  = 7'd0;
        m_mem = 7'd0;
    endtask

    task automatic test_reset();
        logic [14:0] o;
        reset_dut();
        reset = 1'b1;
        #1;
        o = observe();
        n_checks++;
        if (o !== 15'd0) begin
            $display("FAIL reset_state: got %h expected 0", o);
            n_fail++;
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || load_use_events !== 32'd0) begin
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, load_use_events);
            n_fail++;
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_load_use_2();
        stim_t s[$];
        logic [14:0] o, e;
        int nst = 0, nbub = 0;
        reset_dut();
        s.push_back(ld(8));
        for (int k = 0; k < 3; k++) s.push_back(alu(8, 1, 9, 0, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL load_use_2 step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
            if (o[14]) nst++;
            if ((i == 2 || i == 3) && o[13:7] == 7'd0) nbub++;
        end
        n_checks++;
        if (nst != 2) begin $display("FAIL load_use_2 stall_count: got %0d expected 2", nst); n_fail++; end
        n_checks++;
        if (nbub != 2) begin $display("FAIL load_use_2 bubbles: got %0d expected 2", nbub); n_fail++; end
        n_checks++;
        if (o[13:7] !== {1'b1, 5'd9, 1'b0}) begin
            $display("FAIL load_use_2 issued_tag: got %h expected %h", o[13:7], {1'b1, 5'd9, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_load_use_1();
        stim_t s[$];
        logic [14:0] o, e;
        int nst = 0;
        reset_dut();
        s.push_back(ld(8));
        s.push_back(alu(2, 3, 10, 0, 0));
        s.push_back(alu(8, 0, 11, 0, 0));
        s.push_back(alu(8, 0, 11, 0, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL load_use_1 step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
            if (o[14]) nst++;
            if (i == 2) begin
                n_checks++;
                if (o[6:0] !== {1'b1, 5'd8, 1'b1}) begin
                    $display("FAIL load_use_1 mem_tag: got %h expected %h", o[6:0], {1'b1, 5'd8, 1'b1});
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (nst != 1) begin $display("FAIL load_use_1 stall_count: got %0d expected 1", nst); n_fail++; end
    endtask

    task automatic test_zero_reg();
        stim_t s[$];
        logic [14:0] o, e;
        int nst = 0;
        reset_dut();
        s.push_back(ld(0));
        s.push_back(alu(0, 0, 9, 0, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL zero_reg step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
            if (o[14]) nst++;
            if (i == 1) begin
                n_checks++;
                if (o[13] !== 1'b0) begin $display("FAIL zero_reg regwrite: got %b expected 0", o[13]); n_fail++; end
            end
        end
        n_checks++;
        if (nst != 0) begin $display("FAIL zero_reg stall_count: got %0d expected 0", nst); n_fail++; end
    endtask

    task automatic test_flush();
        stim_t s[$];
        logic [14:0] o, e;
        reset_dut();
        s.push_back(ld(8));
        s.push_back(alu(8, 1, 9, 1, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL flush step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
            if (i == 1) begin
                n_checks++;
                if (o[14] !== 1'b0) begin $display("FAIL flush stall: got %b expected 0", o[14]); n_fail++; end
            end
            if (i == 2) begin
                n_checks++;
                if (o[13:0] !== {7'd0, 1'b1, 5'd8, 1'b1}) begin
                    $display("FAIL flush tags: got %h expected %h", o[13:0], {7'd0, 1'b1, 5'd8, 1'b1});
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_hold();
        stim_t s[$];
        logic [14:0] o, e;
        int nst_live = 0, nst_hold = 0;
        reset_dut();
        s.push_back(ld(8));
        s.push_back(alu(1, 8, 9, 0, 0));
        for (int k = 0; k < 3; k++) s.push_back(alu(1, 8, 9, 0, 1));
        s.push_back(alu(1, 8, 9, 0, 0));
        s.push_back(alu(1, 8, 9, 0, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL hold step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
            if (o[14] && s[i].hd) nst_hold++;
            if (o[14] && !s[i].hd) nst_live++;
            if (s[i].hd) begin
                n_checks++;
                if (o !== {1'b1, 7'd0, 1'b1, 5'd8, 1'b1}) begin
                    $display("FAIL hold frozen step %0d: got %h expected %h", i, o, {1'b1, 7'd0, 1'b1, 5'd8, 1'b1});
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (nst_live != 2 || nst_hold != 3) begin
            $display("FAIL hold stall_count: got %0d+%0d expected 2+3", nst_live, nst_hold);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] o, e;
        stim_t s;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            s = op($urandom_range(7) != 0, $urandom_range(1), 5'($urandom_range(3)),
                   $urandom_range(1), 5'($urandom_range(3)), $urandom_range(1),
                   $urandom_range(1), 5'($urandom_range(3)), $urandom_range(7) == 0,
                   $urandom_range(7) == 0);
            step(s);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL back_to_back step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] o, e;
        reset_dut();
        step(ld(8));
        void'(q.pop_front());
        step(alu(8, 1, 9, 0, 0));
        e = q.pop_front();
        o = observe();
        n_checks++;
        if (o !== e || o[14] !== 1'b1) begin
            $display("FAIL reset_mid pre: got %h expected %h", o, e);
            n_fail++;
        end
        reset = 1'b1;
        #1;
        o = observe();
        n_checks++;
        if (o !== 15'd0) begin
            $display("FAIL reset_mid outputs: got %h expected 0", o);
            n_fail++;
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || load_use_events !== 32'd0) begin
            $display("FAIL reset_mid counters: got %0d/%0d expected 0/0", stall_cycles, load_use_events);
            n_fail++;
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        m_ex  = 7'd0;
        m_mem = 7'd0;
        q.delete();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        stim_t s[$];
        logic [14:0] o, e;
        reset_dut();
        s.push_back(ld(8));
        for (int k = 0; k < 3; k++) s.push_back(alu(8, 1, 9, 0, 0));
        s.push_back(nop());
        s.push_back(ld(8));
        s.push_back(alu(2, 3, 10, 0, 0));
        s.push_back(alu(8, 0, 11, 0, 0));
        s.push_back(alu(8, 0, 11, 0, 0));
        s.push_back(nop());
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            e = q.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                $display("FAIL stats step %0d: got %h expected %h", i, o, e);
                n_fail++;
            end
        end
        n_checks++;
        if (stall_cycles !== 32'd3 || load_use_events !== 32'd2) begin
            $display("FAIL stats counters: got %0d/%0d expected 3/2", stall_cycles, load_use_events);
            n_fail++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_ex  = 7'd0;
        m_mem = 7'd0;
        reset = 1'b1;
        apply(nop());
        q.delete();
        test_reset();
        test_load_use_2();
        test_load_use_1();
        test_zero_reg();
        test_flush();
        test_hold();
        test_back_to_back();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
